// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU datapath write-side routing logic.
package cpu_pkg;

   localparam int WIDTH = 16;
   localparam int NDEST = 5;

   localparam logic [2:0] SEL_D0 = 3'd0;
   localparam logic [2:0] SEL_D1 = 3'd1;
   localparam logic [2:0] SEL_D2 = 3'd2;
   localparam logic [2:0] SEL_D3 = 3'd3;
   localparam logic [2:0] SEL_D4 = 3'd4;

   localparam logic [7:0] CNT_MAX = 8'd255;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/qeliza_demux.sv
// One single-entry holding slot with a valid/take handshake toward its consumer.
//
// state      | meaning
// SLOT_EMPTY | no word held, slot can be loaded
// SLOT_FULL  | word held and offered, waits for take (or take+refill)
module qeliza_demux
   import cpu_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         load,
   input  logic         take,
   input  logic [W-1:0] data_in,
   output logic [W-1:0] data_out,
   output logic         valid
);

   slot_state_t state_q, state_d;
   logic [W-1:0] data_q;
   logic         take_ok;
   logic         load_ok;

   // A load into a held word is only legal when the consumer takes it in the same cycle.
   assign take_ok = take & (state_q == SLOT_FULL);
   assign load_ok = load & ((state_q == SLOT_EMPTY) | take_ok);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SLOT_EMPTY: if (load_ok) state_d = SLOT_FULL;
         SLOT_FULL: begin
            if (load_ok)      state_d = SLOT_FULL;
            else if (take_ok) state_d = SLOT_EMPTY;
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load_ok) data_q <= data_in;
      end
   end

   assign data_out = data_q;
   assign valid    = (state_q == SLOT_FULL);

endmodule

// File: rtl/demux1ne5_reg.sv
// Registered 1-to-5 demultiplexer: routes a result word into one of five
// handshaked holding slots, with an invalid-select flag and a write counter.
module demux1ne5_reg
   import cpu_pkg::*;
#(
   parameter int WIDTH_P = WIDTH,
   parameter int NDEST_P = NDEST
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic [WIDTH_P-1:0] Hyrja,
   input  logic [2:0]         S,
   input  logic               Shkruaj,
   output logic               Gati,
   input  logic [NDEST_P-1:0] Merr,
   output logic [WIDTH_P-1:0] Dalja0,
   output logic [WIDTH_P-1:0] Dalja1,
   output logic [WIDTH_P-1:0] Dalja2,
   output logic [WIDTH_P-1:0] Dalja3,
   output logic [WIDTH_P-1:0] Dalja4,
   output logic [NDEST_P-1:0] Valid,
   output logic               Gabim,
   output logic [7:0]         NrShkrimeve
);

   logic [NDEST_P-1:0] sel_oh;
   logic               acc;
   logic               bad_sel;
   logic               gabim_q;
   logic [7:0]         cnt_q;
   logic [WIDTH_P-1:0] dalja_arr [NDEST_P];

   always_comb begin
      sel_oh = '0;
      case (S)
         SEL_D0:  sel_oh[0] = 1'b1;
         SEL_D1:  sel_oh[1] = 1'b1;
         SEL_D2:  sel_oh[2] = 1'b1;
         SEL_D3:  sel_oh[3] = 1'b1;
         SEL_D4:  sel_oh[4] = 1'b1;
         default: sel_oh    = '0;
      endcase
   end

   // Out-of-range selects decode to all-zero, which forces Gati low.
   assign Gati    = |(sel_oh & (~Valid | Merr));
   assign acc     = Shkruaj & Gati;
   assign bad_sel = Shkruaj & ~(|sel_oh);

   for (genvar k = 0; k < NDEST_P; k++) begin : g_slot
      qeliza_demux #(.W(WIDTH_P)) u_slot (
         .Clock    (Clock),
         .Resetn   (Resetn),
         .load     (acc & sel_oh[k]),
         .take     (Merr[k]),
         .data_in  (Hyrja),
         .data_out (dalja_arr[k]),
         .valid    (Valid[k])
      );
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         gabim_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (bad_sel) gabim_q <= 1'b1;
         if (acc && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 8'd1;
      end
   end

   assign Gabim       = gabim_q;
   assign NrShkrimeve = cnt_q;

   assign Dalja0 = dalja_arr[0];
   assign Dalja1 = dalja_arr[1];
   assign Dalja2 = dalja_arr[2];
   assign Dalja3 = dalja_arr[3];
   assign Dalja4 = dalja_arr[4];

endmodule

// File: tb/tb_demux1ne5_reg.sv
// Scoreboard bench for demux1ne5_reg: directed vectors push expected
// post-edge state; a monitor pops and compares after every clock edge.
module tb_demux1ne5_reg;

   typedef struct packed {
      logic [4:0]       valid;
      logic [4:0][15:0] d;
      logic             gabim;
      logic [7:0]       cnt;
   } snap_t;

   logic        Clock;
   logic        Resetn;
   logic [15:0] Hyrja;
   logic [2:0]  S;
   logic        Shkruaj;
   logic        Gati;
   logic [4:0]  Merr;
   logic [15:0] Dalja0, Dalja1, Dalja2, Dalja3, Dalja4;
   logic [4:0]  Valid;
   logic        Gabim;
   logic [7:0]  NrShkrimeve;

   logic [4:0][15:0] dout;
   assign dout = {Dalja4, Dalja3, Dalja2, Dalja1, Dalja0};

   int    n_cmp = 0;
   int    n_err = 0;
   snap_t exp_q[$];
   snap_t m;

   demux1ne5_reg dut (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .Hyrja       (Hyrja),
      .S           (S),
      .Shkruaj     (Shkruaj),
      .Gati        (Gati),
      .Merr        (Merr),
      .Dalja0      (Dalja0),
      .Dalja1      (Dalja1),
      .Dalja2      (Dalja2),
      .Dalja3      (Dalja3),
      .Dalja4      (Dalja4),
      .Valid       (Valid),
      .Gabim       (Gabim),
      .NrShkrimeve (NrShkrimeve)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
      end
   endtask

   // Drive one cycle of inputs, check Gati against the model, then push the
   // expected post-edge state for the monitor.
   task automatic step(input logic [15:0] h, input logic [2:0] s, input logic w,
                       input logic [4:0] mr, input logic rn);
      logic g;
      logic acc;
      @(negedge Clock);
      Hyrja = h; S = s; Shkruaj = w; Merr = mr; Resetn = rn;
      #1;
      if (!rn) begin
         m = '0;
      end else begin
         g = 1'b0;
         if (s < 3'd5) g = !m.valid[s] || mr[s];
         chk("gati_model", {31'd0, Gati}, {31'd0, g});
         acc = w && g;
         for (int k = 0; k < 5; k++) begin
            if (acc && (s == 3'(k))) begin
               m.valid[k] = 1'b1;
               m.d[k]     = h;
            end else if (mr[k] && m.valid[k]) begin
               m.valid[k] = 1'b0;
            end
         end
         if (w && (s >= 3'd5)) m.gabim = 1'b1;
         if (acc && (m.cnt != 8'd255)) m.cnt = m.cnt + 8'd1;
      end
      exp_q.push_back(m);
   endtask

   task automatic after_edge();
      @(posedge Clock);
      #2;
   endtask

   initial begin : monitor
      snap_t e;
      forever begin
         @(posedge Clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_valid", {27'd0, Valid}, {27'd0, e.valid});
            for (int k = 0; k < 5; k++)
               chk($sformatf("sb_dalja%0d", k), {16'd0, dout[k]}, {16'd0, e.d[k]});
            chk("sb_gabim", {31'd0, Gabim}, {31'd0, e.gabim});
            chk("sb_count", {24'd0, NrShkrimeve}, {24'd0, e.cnt});
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [15:0] word;
      int          drained;
      m = '0;
      Resetn = 1'b0; Hyrja = '0; S = '0; Shkruaj = 1'b0; Merr = '0;

      step(16'h0000, 3'd0, 1'b0, 5'b00000, 1'b0);
      after_edge();
      chk("reset_valid", {27'd0, Valid}, 32'h0);
      chk("reset_count", {24'd0, NrShkrimeve}, 32'h0);

      // first write lands in slot 2
      step(16'hA5A5, 3'd2, 1'b1, 5'b00000, 1'b1);
      after_edge();
      chk("wr_valid", {27'd0, Valid}, 32'h04);
      chk("wr_dalja2", {16'd0, Dalja2}, 32'hA5A5);
      chk("wr_dalja0", {16'd0, Dalja0}, 32'h0);
      chk("wr_count", {24'd0, NrShkrimeve}, 32'd1);

      // full slot, no take: write refused
      step(16'h1234, 3'd2, 1'b1, 5'b00000, 1'b1);
      chk("full_gati", {31'd0, Gati}, 32'd0);
      after_edge();
      chk("full_dalja2", {16'd0, Dalja2}, 32'hA5A5);
      chk("full_count", {24'd0, NrShkrimeve}, 32'd1);

      // pass-through refill
      step(16'h1234, 3'd2, 1'b1, 5'b00100, 1'b1);
      chk("refill_gati", {31'd0, Gati}, 32'd1);
      after_edge();
      chk("refill_valid", {27'd0, Valid}, 32'h04);
      chk("refill_dalja2", {16'd0, Dalja2}, 32'h1234);
      chk("refill_count", {24'd0, NrShkrimeve}, 32'd2);

      // invalid select
      step(16'hDEAD, 3'd6, 1'b1, 5'b00000, 1'b1);
      chk("badsel_gati", {31'd0, Gati}, 32'd0);
      after_edge();
      chk("badsel_gabim", {31'd0, Gabim}, 32'd1);
      chk("badsel_valid", {27'd0, Valid}, 32'h04);
      chk("badsel_count", {24'd0, NrShkrimeve}, 32'd2);

      for (int i = 0; i < 10; i++)
         step(16'h3000 + 16'(i), 3'd3, 1'b1, 5'b01000, 1'b1);
      after_edge();
      chk("sticky_gabim", {31'd0, Gabim}, 32'd1);
      chk("sticky_count", {24'd0, NrShkrimeve}, 32'd12);
      chk("sticky_dalja3", {16'd0, Dalja3}, 32'h3009);

      // take all at once; data holds
      step(16'h0000, 3'd0, 1'b0, 5'b11111, 1'b1);
      after_edge();
      chk("takeall_valid", {27'd0, Valid}, 32'h0);
      chk("takeall_dalja2", {16'd0, Dalja2}, 32'h1234);

      for (int i = 0; i < 300; i++) begin
         word = 16'(i * 257) ^ 16'h5A5A;
         step(word, 3'd0, 1'b1, 5'b00001, 1'b1);
      end
      after_edge();
      chk("sat_count", {24'd0, NrShkrimeve}, 32'd255);
      chk("sat_dalja0", {16'd0, Dalja0}, {16'd0, 16'(299 * 257) ^ 16'h5A5A});
      chk("sat_valid", {27'd0, Valid}, 32'h01);

      step(16'h0000, 3'd0, 1'b0, 5'b11111, 1'b1);
      for (int k = 0; k < 5; k++)
         step(16'hC000 + 16'(k), 3'(k), 1'b1, 5'b00000, 1'b1);
      after_edge();
      chk("fill_valid", {27'd0, Valid}, 32'h1F);
      chk("fill_dalja4", {16'd0, Dalja4}, 32'hC004);

      // reset with a write in flight
      step(16'hFFFF, 3'd1, 1'b1, 5'b00010, 1'b0);
      after_edge();
      chk("rst_valid", {27'd0, Valid}, 32'h0);
      chk("rst_dalja1", {16'd0, Dalja1}, 32'h0);
      chk("rst_dalja4", {16'd0, Dalja4}, 32'h0);
      chk("rst_gabim", {31'd0, Gabim}, 32'd0);
      chk("rst_count", {24'd0, NrShkrimeve}, 32'd0);

      step(16'h7777, 3'd4, 1'b1, 5'b00000, 1'b1);
      after_edge();
      chk("post_rst_valid", {27'd0, Valid}, 32'h10);
      chk("post_rst_count", {24'd0, NrShkrimeve}, 32'd1);

      drained = 0;
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() == 0) begin
            drained = 1;
            break;
         end
         @(posedge Clock);
         #2;
      end
      chk("sb_drained", drained, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
